// File: rtl/deserializer_10b_ddr.sv
// 10b receive deserializer: two IDDR bits per cycle, K28.5 comma alignment
// over all ten bit positions, aligned code groups out to the 8b10b decoder.
//
// state  | meaning
// HUNT   | no alignment; any comma seeds a candidate
// CHECK  | counting consecutive commas at the candidate alignment
// LOCKED | words emitted at the locked alignment; misaligned commas counted
module deserializer_10b_ddr #(
  parameter logic [9:0]  COMMA_P  = 10'h17C,
  parameter logic [9:0]  COMMA_N  = 10'h283,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic       clk_bit,
  input  logic       rst,
  input  logic       din_first,
  input  logic       din_second,
  input  logic       align_en,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       is_comma,
  output logic       locked,
  output logic [2:0] align_phase,
  output logic       align_bit
);

  localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TH = 4'(LOSS_CNT);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [11:0] hist_q, hist_d;
  logic [2:0]  ph_q, ph_d;
  logic [2:0]  cand_ph_q, cand_ph_d, lk_ph_q, lk_ph_d;
  logic        cand_off_q, cand_off_d, lk_off_q, lk_off_d;
  logic [3:0]  cnt_q, cnt_d, miss_q, miss_d;
  logic [9:0]  dout_q, dout_d;
  logic        valid_q, valid_d, comma_q, comma_d;

  logic [9:0]  win0, win1;
  logic        hit0, hit1, hit_any, hit_off, aligned;
  logic [2:0]  ref_ph;
  logic        ref_off;

  assign hist_d  = {din_second, din_first, hist_q[11:2]};
  assign win0    = hist_q[9:0];
  assign win1    = hist_q[10:1];
  assign hit0    = (win0 == COMMA_P) || (win0 == COMMA_N);
  assign hit1    = (win1 == COMMA_P) || (win1 == COMMA_N);
  assign hit_any = hit0 | hit1;
  assign hit_off = ~hit0;
  assign ph_d    = (ph_q == 3'd4) ? 3'd0 : ph_q + 3'd1;

  // While locked, commas are judged against the locked slot; otherwise the candidate.
  assign ref_ph  = (state_q == LOCKED) ? lk_ph_q  : cand_ph_q;
  assign ref_off = (state_q == LOCKED) ? lk_off_q : cand_off_q;
  assign aligned = (ph_q == ref_ph) && (ref_off ? hit1 : hit0);

  always_comb begin
    state_d    = state_q;
    cand_ph_d  = cand_ph_q;
    cand_off_d = cand_off_q;
    lk_ph_d    = lk_ph_q;
    lk_off_d   = lk_off_q;
    cnt_d      = cnt_q;
    miss_d     = miss_q;
    if (align_en) begin
      unique case (state_q)
        HUNT: begin
          if (hit_any) begin
            cand_ph_d  = ph_q;
            cand_off_d = hit_off;
            cnt_d      = 4'd1;
            state_d    = CHECK;
            if (LOCK_TH == 4'd1) begin
              lk_ph_d  = ph_q;
              lk_off_d = hit_off;
              miss_d   = 4'd0;
              state_d  = LOCKED;
            end
          end
        end
        CHECK: begin
          if (aligned) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= LOCK_TH) begin
              lk_ph_d  = cand_ph_q;
              lk_off_d = cand_off_q;
              miss_d   = 4'd0;
              state_d  = LOCKED;
            end
          end else if (hit_any) begin
            cand_ph_d  = ph_q;
            cand_off_d = hit_off;
            cnt_d      = 4'd1;
          end
        end
        LOCKED: begin
          if (aligned) begin
            miss_d = 4'd0;
          end else if (hit_any) begin
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 >= LOSS_TH) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Using the next lock slot lets the lock-completing comma itself be emitted.
  always_comb begin
    dout_d  = dout_q;
    comma_d = comma_q;
    valid_d = 1'b0;
    if ((state_q == LOCKED || state_d == LOCKED) && ph_q == lk_ph_d) begin
      dout_d  = lk_off_d ? win1 : win0;
      comma_d = lk_off_d ? hit1 : hit0;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_bit) begin
    if (rst) begin
      state_q    <= HUNT;
      hist_q     <= '0;
      ph_q       <= '0;
      cand_ph_q  <= '0;
      cand_off_q <= 1'b0;
      lk_ph_q    <= '0;
      lk_off_q   <= 1'b0;
      cnt_q      <= '0;
      miss_q     <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      comma_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      ph_q       <= ph_d;
      cand_ph_q  <= cand_ph_d;
      cand_off_q <= cand_off_d;
      lk_ph_q    <= lk_ph_d;
      lk_off_q   <= lk_off_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      comma_q    <= comma_d;
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign is_comma    = comma_q;
  assign locked      = (state_q == LOCKED);
  assign align_phase = lk_ph_q;
  assign align_bit   = lk_off_q;

endmodule

// File: tb/tb_deserializer_10b_ddr.sv
// Bench for deserializer_10b_ddr: bit-stream reference model where an alignment
// is the received-bit index of a word start modulo 10.
module tb_deserializer_10b_ddr;

  localparam logic [9:0] COMMA_P  = 10'h17C;
  localparam logic [9:0] COMMA_N  = 10'h283;
  localparam logic [9:0] FILL     = 10'h2AA;
  localparam int         LOCK_CNT = 3;
  localparam int         LOSS_CNT = 4;
  localparam int         S_HUNT = 0, S_CHECK = 1, S_LOCKED = 2;

  logic       clk_bit = 1'b0;
  logic       rst = 1'b1, din_first = 1'b0, din_second = 1'b0, align_en = 1'b0;
  logic [9:0] data_out;
  logic       data_valid, is_comma, locked, align_bit;
  logic [2:0] align_phase;
  logic [16:0] dut_vec;

  always #5 clk_bit = ~clk_bit;

  deserializer_10b_ddr dut (
    .clk_bit(clk_bit), .rst(rst), .din_first(din_first), .din_second(din_second),
    .align_en(align_en), .data_out(data_out), .data_valid(data_valid),
    .is_comma(is_comma), .locked(locked), .align_phase(align_phase), .align_bit(align_bit)
  );

  assign dut_vec = {data_out, data_valid, is_comma, locked, align_phase, align_bit};

  int n_chk = 0, n_pass = 0;
  bit txq[$];
  bit s_q[$];   // every bit seen since reset, led by 12 zeros for the cleared history
  int m_state = S_HUNT, m_cand = 0, m_lk = 0, m_cnt = 0, m_miss = 0;
  logic [9:0] m_dout = '0;
  logic m_valid = 1'b0, m_comma = 1'b0;

  function automatic logic [9:0] word_at(int p);
    logic [9:0] w;
    for (int k = 0; k < 10; k++) w[k] = s_q[p + k];
    return w;
  endfunction

  function automatic logic [16:0] exp_vec();
    return {m_dout, m_valid, m_comma, m_state == S_LOCKED, 3'(m_lk / 2), 1'(m_lk % 2)};
  endfunction

  task automatic model_step(input bit r, input bit f, input bit sc, input bit en);
    int base, c0, c1, hit_cls, ref_cls, old_state;
    logic [9:0] w0, w1;
    bit h0, h1, any_hit, aligned;
    if (r) begin
      s_q.delete();
      repeat (12) s_q.push_back(1'b0);
      m_state = S_HUNT; m_cand = 0; m_lk = 0; m_cnt = 0; m_miss = 0;
      m_dout = '0; m_valid = 1'b0; m_comma = 1'b0;
      return;
    end
    base = s_q.size() - 12;
    c0 = base % 10;
    c1 = (base + 1) % 10;
    w0 = word_at(base);
    w1 = word_at(base + 1);
    h0 = (w0 == COMMA_P) || (w0 == COMMA_N);
    h1 = (w1 == COMMA_P) || (w1 == COMMA_N);
    any_hit = h0 | h1;
    hit_cls = h0 ? c0 : c1;
    ref_cls = (m_state == S_LOCKED) ? m_lk : m_cand;
    aligned = (h0 && ref_cls == c0) || (h1 && ref_cls == c1);
    old_state = m_state;
    if (en && any_hit) begin
      case (m_state)
        S_HUNT: begin
          m_cand = hit_cls; m_cnt = 1; m_state = S_CHECK;
          if (LOCK_CNT == 1) begin m_lk = m_cand; m_miss = 0; m_state = S_LOCKED; end
        end
        S_CHECK: begin
          if (aligned) begin
            m_cnt++;
            if (m_cnt >= LOCK_CNT) begin m_lk = m_cand; m_miss = 0; m_state = S_LOCKED; end
          end else begin
            m_cand = hit_cls; m_cnt = 1;
          end
        end
        default: begin
          if (aligned) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss >= LOSS_CNT) m_state = S_HUNT;
          end
        end
      endcase
    end
    m_valid = 1'b0;
    if (old_state == S_LOCKED || m_state == S_LOCKED) begin
      if (m_lk == c0) begin m_valid = 1'b1; m_dout = w0; m_comma = h0; end
      else if (m_lk == c1) begin m_valid = 1'b1; m_dout = w1; m_comma = h1; end
    end
    s_q.push_back(f);
    s_q.push_back(sc);
  endtask

  task automatic push_word(input logic [9:0] w);
    for (int k = 0; k < 10; k++) txq.push_back(w[k]);
  endtask

  task automatic push_groups(input int n);
    repeat (n) begin
      push_word(COMMA_P);
      repeat (4) push_word(FILL);
    end
  endtask

  task automatic push_pad(input int n, input bit first);
    bit b;
    b = first;
    repeat (n) begin txq.push_back(b); b = ~b; end
  endtask

  task automatic tick(input bit r, input bit en);
    bit f, sc;
    if (txq.size() < 2) push_word(FILL);
    f = txq.pop_front();
    sc = txq.pop_front();
    rst = r; align_en = en; din_first = f; din_second = sc;
    @(posedge clk_bit);
    model_step(r, f, sc, en);
    @(negedge clk_bit);
  endtask

  task automatic do_reset(input int n);
    txq.delete();
    push_pad(2 * n, 1'($urandom_range(0, 1)));
    repeat (n) tick(1'b1, 1'($urandom_range(0, 1)));
    txq.delete();
  endtask

  task automatic test_reset();
    txq.delete();
    for (int i = 0; i < 6; i++) txq.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)));
      n_chk++;
      if (dut_vec !== 17'd0) $display("FAIL reset_outputs cycle %0d: got %h want 0", i, dut_vec);
      else n_pass++;
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL reset_model cycle %0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_lock(input bit odd);
    int t_lock;
    bit exp_v, exp_c;
    logic [9:0] exp_w;
    do_reset(2);
    if (odd) push_pad(1, 1'b1);
    push_groups(6);
    t_lock = -1;
    for (int i = 1; i <= 200 && t_lock < 0; i++) begin
      tick(1'b0, 1'b1);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL lock%0d_model tick %0d: got %h want %h", odd, i, dut_vec, exp_vec());
      else n_pass++;
      if (locked === 1'b1) t_lock = i;
    end
    n_chk++;
    if (t_lock !== 57) $display("FAIL lock%0d_time: got tick %0d want 57", odd, t_lock);
    else n_pass++;
    n_chk++;
    if ({data_valid, is_comma, data_out, align_phase, align_bit} !== {1'b1, 1'b1, COMMA_P, 3'd1, odd})
      $display("FAIL lock%0d_first_word: got v=%b c=%b d=%h ph=%0d b=%b want v=1 c=1 d=17c ph=1 b=%b",
               odd, data_valid, is_comma, data_out, align_phase, align_bit, odd);
    else n_pass++;
    for (int i = 1; i <= 25; i++) begin
      tick(1'b0, 1'b1);
      exp_v = (i % 5 == 0);
      exp_c = (i == 25);
      exp_w = exp_c ? COMMA_P : FILL;
      n_chk++;
      if (data_valid !== exp_v || (exp_v && (data_out !== exp_w || is_comma !== exp_c)))
        $display("FAIL lock%0d_word_seq +%0d: got v=%b d=%h c=%b want v=%b d=%h c=%b",
                 odd, i, data_valid, data_out, is_comma, exp_v, exp_w, exp_c);
      else n_pass++;
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL lock%0d_model +%0d: got %h want %h", odd, i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_candidate_restart();
    int t_lock;
    do_reset(2);
    push_groups(2);
    push_pad(3, 1'b0);
    push_groups(6);
    t_lock = -1;
    for (int i = 1; i <= 300 && t_lock < 0; i++) begin
      tick(1'b0, 1'b1);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL restart_model tick %0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (locked === 1'b1) t_lock = i;
    end
    n_chk++;
    if (t_lock !== 108) $display("FAIL restart_lock_time: got tick %0d want 108", t_lock);
    else n_pass++;
    n_chk++;
    if ({align_phase, align_bit} !== {3'd2, 1'b1})
      $display("FAIL restart_alignment: got ph=%0d b=%b want ph=2 b=1", align_phase, align_bit);
    else n_pass++;
  endtask

  task automatic test_loss_of_lock();
    int t1, tf, t2, drops;
    do_reset(2);
    push_groups(3);
    push_pad(1, 1'b1);
    push_groups(7);
    push_pad(1, 1'b1);
    push_groups(3);
    push_pad(9, 1'b1);
    push_groups(1);
    push_pad(1, 1'b1);
    push_groups(3);
    push_pad(9, 1'b1);
    push_groups(3);
    t1 = -1; tf = -1; t2 = -1; drops = 0;
    for (int i = 1; i <= 500; i++) begin
      tick(1'b0, 1'b1);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL loss_model tick %0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (t1 < 0) begin
        if (locked === 1'b1) t1 = i;
      end else if (tf < 0) begin
        if (locked !== 1'b1) tf = i;
      end else if (t2 < 0) begin
        if (locked === 1'b1) t2 = i;
      end else if (locked !== 1'b1) drops++;
    end
    n_chk++;
    if (t1 !== 57) $display("FAIL loss_first_lock: got tick %0d want 57", t1); else n_pass++;
    n_chk++;
    if (tf !== 157) $display("FAIL loss_fall: got tick %0d want 157", tf); else n_pass++;
    n_chk++;
    if (t2 !== 232) $display("FAIL loss_relock: got tick %0d want 232", t2); else n_pass++;
    n_chk++;
    if (drops !== 0) $display("FAIL loss_miss_cleared: got %0d unlocked ticks want 0", drops); else n_pass++;
    n_chk++;
    if ({align_phase, align_bit} !== {3'd1, 1'b1})
      $display("FAIL loss_alignment: got ph=%0d b=%b want ph=1 b=1", align_phase, align_bit);
    else n_pass++;
  endtask

  task automatic test_freeze_and_reset();
    int t_lock, nv, unl;
    do_reset(2);
    push_groups(3);
    push_pad(1, 1'b1);
    push_groups(4);
    t_lock = -1;
    for (int i = 1; i <= 100 && t_lock < 0; i++) begin
      tick(1'b0, 1'b1);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL freeze_model tick %0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (locked === 1'b1) t_lock = i;
    end
    n_chk++;
    if (t_lock !== 57) $display("FAIL freeze_lock_time: got tick %0d want 57", t_lock); else n_pass++;
    nv = 0; unl = 0;
    for (int i = 1; i <= 120; i++) begin
      tick(1'b0, 1'b0);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL freeze_model +%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (data_valid === 1'b1) nv++;
      if (locked !== 1'b1) unl++;
    end
    n_chk++;
    if (nv !== 24 || unl !== 0 || {align_phase, align_bit} !== {3'd1, 1'b0})
      $display("FAIL freeze_hold: got valids=%0d unlocked=%0d ph=%0d b=%b want 24 0 1 0",
               nv, unl, align_phase, align_bit);
    else n_pass++;
    tick(1'b1, 1'b1);
    n_chk++;
    if ({locked, data_valid} !== 2'b00) $display("FAIL midlock_reset: got locked=%b valid=%b want 0 0", locked, data_valid);
    else n_pass++;
    txq.delete();
    push_groups(6);
    t_lock = -1;
    for (int i = 1; i <= 100 && t_lock < 0; i++) begin
      tick(1'b0, 1'b1);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL relock_model tick %0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (locked === 1'b1) t_lock = i;
    end
    n_chk++;
    if (t_lock !== 57) $display("FAIL relock_after_reset: got tick %0d want 57", t_lock); else n_pass++;
  endtask

  task automatic test_random();
    int sel;
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      if (txq.size() < 2) begin
        sel = $urandom_range(0, 99);
        if (sel < 30) push_word(($urandom_range(0, 1) == 0) ? COMMA_P : COMMA_N);
        else if (sel < 85) push_word(10'($urandom));
        else push_pad($urandom_range(1, 9), 1'($urandom_range(0, 1)));
      end
      tick(1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 9) != 0));
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL random_model step %0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    @(negedge clk_bit);
    test_reset();
    test_lock(1'b0);
    test_lock(1'b1);
    test_candidate_restart();
    test_loss_of_lock();
    test_freeze_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
